// File: rtl/pkt_reader.sv
`default_nettype none
// ============================================================================
// Module   : pkt_reader
// Purpose  : Pops fixed-size packets from a show-ahead FIFO onto a
//            valid/ready stream with SOP/EOP markers and an 8-bit checksum.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_SIZE   = 10
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  start,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  r_inc,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  busy,
    output logic                  pkt_done,
    output logic [7:0]            checksum
);

    localparam int CNT_W = $clog2(PKT_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [7:0]       rd_low8;
    logic             accept;

    generate
        if (DATA_WIDTH >= 8) begin : g_low8_slice
            assign rd_low8 = rd_data[7:0];
        end else begin : g_low8_pad
            assign rd_low8 = {{(8-DATA_WIDTH){1'b0}}, rd_data};
        end
    endgenerate

    assign accept = out_valid && out_ready;

    // Pop only when the output register is free or being drained this cycle.
    assign r_inc = !r_rst && (state == READ) && !empty && (!out_valid || out_ready);

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            state     <= IDLE;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            busy      <= 1'b0;
            pkt_done  <= 1'b0;
            checksum  <= 8'd0;
        end else begin
            pkt_done <= 1'b0;

            if (r_inc) begin
                out_data  <= rd_data;
                out_valid <= 1'b1;
                out_sop   <= (count == '0);
                out_eop   <= (count == CNT_W'(PKT_SIZE - 1));
                count     <= count + 1'b1;
                checksum  <= checksum + rd_low8;
            end else if (accept) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= READ;
                        count    <= '0;
                        checksum <= 8'd0;
                        busy     <= 1'b1;
                    end
                end
                READ: begin
                    if (r_inc && (count == CNT_W'(PKT_SIZE - 1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept && out_eop) begin
                        state    <= DONE;
                        pkt_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/pkt_reader.md
PKT_READER -- requirements
Module: pkt_reader

Parameters
REQ-001 SHALL have parameter DATA_WIDTH, default 8, FIFO and output data width in bits.
REQ-002 SHALL have parameter PKT_SIZE, default 10, number of words per packet (legal range 2..255).

Interface
REQ-003 SHALL have R_CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have R_RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have START  input  1  one-cycle request to read one packet.
REQ-006 SHALL have EMPTY  input  1  FIFO read-side empty flag.
REQ-007 SHALL have RD_DATA  input  DATA_WIDTH  FIFO head word, valid whenever EMPTY=0 (show-ahead).
REQ-008 SHALL have R_INC  output  1  FIFO pop; the head word is consumed at each rising edge with R_INC=1.
REQ-009 SHALL have OUT_DATA  output  DATA_WIDTH  registered packet word.
REQ-010 SHALL have OUT_VALID  output  1  OUT_DATA holds an unaccepted word.
REQ-011 SHALL have OUT_READY  input  1  downstream accepts the word when OUT_VALID=1 and OUT_READY=1 at a rising edge.
REQ-012 SHALL have OUT_SOP / OUT_EOP  output  1 each  first and last word markers, qualified by OUT_VALID.
REQ-013 SHALL have BUSY  output  1  high from the cycle after an accepted START until the cycle after PKT_DONE.
REQ-014 SHALL have PKT_DONE  output  1  one-cycle pulse after the last word is accepted.
REQ-015 SHALL have CHECKSUM  output  8  modulo-256 sum of the low 8 bits of every word of the current or last packet.

Function
REQ-016 SHALL implement the states IDLE, READ, DRAIN and DONE.
REQ-017 IDLE: START=1 SHALL go to READ, clear the word counter and CHECKSUM, and set BUSY. START=0 SHALL leave the state unchanged.
REQ-018 START SHALL be ignored in any state other than IDLE.
REQ-019 READ: R_INC SHALL be the combinational term (state==READ) AND !EMPTY AND (!OUT_VALID OR OUT_READY), so the block never pops while EMPTY=1 and never overwrites an unaccepted word.
REQ-020 On each pop edge, the block SHALL perform all of the following:
  - OUT_DATA<=RD_DATA and OUT_VALID<=1, giving 1-cycle pop-to-valid latency;
  - OUT_SOP<=(count==0) and OUT_EOP<=(count==PKT_SIZE-1);
  - increment count;
  - CHECKSUM<=CHECKSUM+RD_DATA[7:0], wrapping at 256.
REQ-021 An accepted word with no pop in the same cycle SHALL clear OUT_VALID. Accept and pop in the same cycle SHALL keep OUT_VALID=1 and present the new word, giving full throughput of 1 word per cycle.
REQ-022 READ: the pop of word PKT_SIZE-1 SHALL move the block to DRAIN, and R_INC SHALL be 0 from the next cycle.
REQ-023 DRAIN: acceptance of the EOP word SHALL move the block to DONE.
REQ-024 DONE SHALL last exactly one cycle with PKT_DONE=1 and then return to IDLE. BUSY SHALL fall one cycle later.
REQ-025 CHECKSUM SHALL hold its final value from DONE until the next accepted START.
REQ-026 EMPTY=1 during READ SHALL stall without error for any number of cycles.
REQ-027 OUT_READY=0 SHALL hold OUT_DATA, OUT_SOP and OUT_EOP stable while OUT_VALID=1.
REQ-028 The word counter SHALL be ceil(log2(PKT_SIZE+1)) bits wide and SHALL never exceed PKT_SIZE.

Reset
REQ-029 R_RST=1 SHALL immediately force state=IDLE, count=0, OUT_DATA=0, OUT_VALID=0, OUT_SOP=0, OUT_EOP=0, BUSY=0, PKT_DONE=0 and CHECKSUM=0.
REQ-030 R_RST=1 SHALL force R_INC=0 combinationally, so no FIFO word is consumed during reset.
REQ-031 A reset mid-packet SHALL abandon the partial packet with no PKT_DONE. Words already popped are lost, and the first word accepted after reset SHALL carry SOP only after a new START.

Verification
REQ-032 Basic packet: FIFO preloaded with 10 words 0x01..0x0A, OUT_READY=1, START pulse. The bench SHALL observe:
  - R_INC high for 10 consecutive cycles;
  - OUT_VALID for 10 cycles, SOP on 0x01 and EOP on 0x0A;
  - PKT_DONE 1 cycle after 0x0A is accepted;
  - CHECKSUM=0x37.
REQ-033 Starved FIFO: words written one every 4 cycles. R_INC SHALL never assert with EMPTY=1, all 10 words SHALL arrive in order, and PKT_DONE SHALL pulse once.
REQ-034 Backpressure: OUT_READY toggles 1,0,0,1 repeatedly. OUT_DATA SHALL stay stable while stalled, no word SHALL be lost or duplicated, and the FIFO SHALL pop exactly 10 words.
REQ-035 Extra START and wrap: START pulses during READ and again during DONE. Neither SHALL have any effect. Words 0xFF x10 SHALL give CHECKSUM=0xF6.
REQ-036 Reset mid-packet: R_RST asserted after 4 pops. All outputs SHALL be 0 immediately and no PKT_DONE SHALL occur. A new START SHALL then read the next 10 FIFO words, with SOP on the 5th original word.
REQ-037 Back-to-back packets: 20 words preloaded, START asserted on the cycle after PKT_DONE. The second packet SHALL begin with SOP and produce its own PKT_DONE and CHECKSUM.
